// File: rtl/f2h_dma_pkg.sv
// f2h_dma_pkg
// Shared types for the f2h DMA request sequencer.
//   ch_state_e : per-channel handshake state
//   req_kind_e : burst or single request flavour
//   GAP_W      : width of the inter-request gap counter
package f2h_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } ch_state_e;

  typedef enum logic {
    KIND_BURST  = 1'b0,
    KIND_SINGLE = 1'b1
  } req_kind_e;

  localparam int unsigned GAP_W = 4;

endpackage

// File: rtl/f2h_dma_ch_fsm.sv
// f2h_dma_ch_fsm
// One HPS f2h DMA request channel: turns a level request into a held
// burst/single request, waits for the HPS ack, pulses src_ack, then
// enforces an idle gap. An ack timeout drops the request and sets a
// sticky tmo_err. Dropping ch_enable aborts everything and clears tmo_err.
// Ports:
//   clk, rst_n        clock, async active-low reset (already synchronised)
//   ch_enable         channel enable; low forces IDLE
//   burst_thr         level at or above which a burst is requested
//   src_req/src_level requester service request and FIFO level
//   dma_ack           ack from the HPS DMA controller
//   src_ack           one-cycle completion pulse to the requester
//   dma_req/dma_single held burst / single request to the HPS
//   busy              request outstanding
//   tmo_err           sticky ack-timeout flag
module f2h_dma_ch_fsm
  import f2h_dma_pkg::*;
#(
  parameter int unsigned LVL_W   = 8,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TMO_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_enable,
  input  logic [LVL_W-1:0] burst_thr,
  input  logic             src_req,
  input  logic [LVL_W-1:0] src_level,
  input  logic             dma_ack,
  output logic             src_ack,
  output logic             dma_req,
  output logic             dma_single,
  output logic             busy,
  output logic             tmo_err
);

  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_PEN  = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  // With no gap configured a finished transfer returns straight to IDLE.
  localparam ch_state_e POST_XFER = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

  ch_state_e        state_r;
  req_kind_e        kind_s;
  logic [LVL_W-1:0] lvl_q_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             src_ack_r;
  logic             dma_req_r;
  logic             dma_single_r;
  logic             busy_r;
  logic             tmo_err_r;

  // Burst only when the captured level is non-empty and meets the threshold.
  always_comb begin
    if ((lvl_q_r != '0) && (lvl_q_r >= burst_thr)) begin
      kind_s = KIND_BURST;
    end else begin
      kind_s = KIND_SINGLE;
    end
  end

  // Channel FSM with registered handshake outputs and gap/timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      lvl_q_r      <= '0;
      gap_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      src_ack_r    <= 1'b0;
      dma_req_r    <= 1'b0;
      dma_single_r <= 1'b0;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
    end else if (!ch_enable) begin
      // Disable aborts any handshake; a same-cycle ack is deliberately lost.
      state_r      <= ST_IDLE;
      gap_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      src_ack_r    <= 1'b0;
      dma_req_r    <= 1'b0;
      dma_single_r <= 1'b0;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
    end else begin
      src_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (src_req) begin
            lvl_q_r <= src_level;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          dma_req_r    <= (kind_s == KIND_BURST);
          dma_single_r <= (kind_s == KIND_SINGLE);
          busy_r       <= 1'b1;
          tmo_cnt_r    <= '0;
          state_r      <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ack is checked first so it beats a coincident terminal count.
          if (dma_ack) begin
            dma_req_r    <= 1'b0;
            dma_single_r <= 1'b0;
            busy_r       <= 1'b0;
            src_ack_r    <= 1'b1;
            gap_cnt_r    <= '0;
            state_r      <= POST_XFER;
          end else if (tmo_cnt_r == TMO_PEN) begin
            tmo_cnt_r    <= TMO_MAX;
            tmo_err_r    <= 1'b1;
            dma_req_r    <= 1'b0;
            dma_single_r <= 1'b0;
            busy_r       <= 1'b0;
            gap_cnt_r    <= '0;
            state_r      <= POST_XFER;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          dma_req_r    <= 1'b0;
          dma_single_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign src_ack    = src_ack_r;
  assign dma_req    = dma_req_r;
  assign dma_single = dma_single_r;
  assign busy       = busy_r;
  assign tmo_err    = tmo_err_r;

endmodule

// File: rtl/f2h_dma_req_sequencer.sv
// f2h_dma_req_sequencer
// Drives the HPS f2h_dma_req0..N-1 burst/single handshakes for fabric
// requesters. One independent f2h_dma_ch_fsm per channel; this level
// slices the requester levels and synchronises reset release.
// Ports:
//   clk_clk, reset_reset_n  clock, async active-low reset
//   ch_enable   per-channel enable
//   burst_thr   shared burst threshold
//   src_req     requester service request (level)
//   src_level   requester levels, channel c at [c*LVL_W +: LVL_W]
//   src_ack     one-cycle completion pulse per channel
//   dma_req     burst request to HPS
//   dma_single  single request to HPS
//   dma_ack     ack from HPS
//   busy        request outstanding per channel
//   tmo_err     sticky ack-timeout per channel
module f2h_dma_req_sequencer
  import f2h_dma_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LVL_W   = 8,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [LVL_W-1:0]        burst_thr,
  input  logic [NUM_CH-1:0]       src_req,
  input  logic [NUM_CH*LVL_W-1:0] src_level,
  output logic [NUM_CH-1:0]       src_ack,
  output logic [NUM_CH-1:0]       dma_req,
  output logic [NUM_CH-1:0]       dma_single,
  input  logic [NUM_CH-1:0]       dma_ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       tmo_err
);

  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Reset asserts immediately and releases two clocks after the pin does.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    f2h_dma_ch_fsm #(
      .LVL_W   (LVL_W),
      .GAP_CYC (GAP_CYC),
      .TMO_W   (TMO_W)
    ) u_ch (
      .clk        (clk_clk),
      .rst_n      (rst_n_s),
      .ch_enable  (ch_enable[c]),
      .burst_thr  (burst_thr),
      .src_req    (src_req[c]),
      .src_level  (src_level[c*LVL_W +: LVL_W]),
      .dma_ack    (dma_ack[c]),
      .src_ack    (src_ack[c]),
      .dma_req    (dma_req[c]),
      .dma_single (dma_single[c]),
      .busy       (busy[c]),
      .tmo_err    (tmo_err[c])
    );
  end

endmodule

// File: tb/tb_f2h_dma_req_sequencer.sv
// Directed bench for f2h_dma_req_sequencer with a timestamp-based
// behavioural model checked every cycle, plus literal spot checks.
module tb_f2h_dma_req_sequencer;

  localparam int NCH = 4;
  localparam int GAP = 2;
  localparam int TMO_LIMIT = 65535;

  logic        clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  ch_enable;
  logic [7:0]  burst_thr;
  logic [3:0]  src_req;
  logic [31:0] src_level;
  logic [3:0]  dma_ack;
  logic [3:0]  src_ack;
  logic [3:0]  dma_req;
  logic [3:0]  dma_single;
  logic [3:0]  busy;
  logic [3:0]  tmo_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: per channel, visible request, its flavour, timestamps
  bit         m_out  [NCH];
  bit         m_burst[NCH];
  bit         m_tmo  [NCH];
  bit         m_ack  [NCH];
  bit         m_pend [NCH];
  int         m_wait [NCH];
  int         m_free [NCH];
  int         m_start[NCH];
  logic [7:0] m_lvl  [NCH];

  f2h_dma_req_sequencer dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .ch_enable     (ch_enable),
    .burst_thr     (burst_thr),
    .src_req       (src_req),
    .src_level     (src_level),
    .src_ack       (src_ack),
    .dma_req       (dma_req),
    .dma_single    (dma_single),
    .dma_ack       (dma_ack),
    .busy          (busy),
    .tmo_err       (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one edge using the inputs of cycle cyc.
  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      m_ack[c] = 1'b0;
      if (!reset_reset_n) begin
        m_out[c] = 0; m_tmo[c] = 0; m_pend[c] = 0; m_free[c] = 0; m_burst[c] = 0;
      end else if (!ch_enable[c]) begin
        m_out[c] = 0; m_tmo[c] = 0; m_pend[c] = 0; m_free[c] = cyc + 1;
      end else if (m_out[c]) begin
        if (dma_ack[c]) begin
          m_out[c] = 0; m_ack[c] = 1; m_free[c] = cyc + 1 + GAP;
        end else begin
          m_wait[c]++;
          if (m_wait[c] == TMO_LIMIT) begin
            m_out[c] = 0; m_tmo[c] = 1; m_free[c] = cyc + 1 + GAP;
          end
        end
      end else if (m_pend[c] && (m_start[c] == cyc + 1)) begin
        m_pend[c]  = 0;
        m_out[c]   = 1;
        m_burst[c] = (m_lvl[c] != 8'd0) && (m_lvl[c] >= burst_thr);
        m_wait[c]  = 0;
      end else if (!m_pend[c] && (cyc >= m_free[c]) && src_req[c]) begin
        m_pend[c]  = 1;
        m_lvl[c]   = src_level[c*8 +: 8];
        m_start[c] = cyc + 2;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_ack, e_req, e_sgl, e_busy, e_tmo;
    for (int c = 0; c < NCH; c++) begin
      e_ack[c]  = m_ack[c];
      e_req[c]  = m_out[c] & m_burst[c];
      e_sgl[c]  = m_out[c] & ~m_burst[c];
      e_busy[c] = m_out[c];
      e_tmo[c]  = m_tmo[c];
    end
    chk("src_ack", src_ack, e_ack);
    chk("dma_req", dma_req, e_req);
    chk("dma_single", dma_single, e_sgl);
    chk("busy", busy, e_busy);
    chk("tmo_err", tmo_err, e_tmo);
    chk("req_excl", dma_req & dma_single, 4'b0000);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int ack_at[NCH] = '{4, 6, 7, 9};
  logic [7:0] thr_tab[2] = '{8'd8, 8'd0};
  logic [3:0] req_tab[2] = '{4'b0101, 4'b0111};
  logic [3:0] sgl_tab[2] = '{4'b1010, 4'b1000};

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = 0; m_burst[c] = 0; m_tmo[c] = 0; m_ack[c] = 0;
      m_pend[c] = 0; m_wait[c] = 0; m_free[c] = 0; m_start[c] = 0; m_lvl[c] = 8'd0;
    end
    reset_reset_n = 1'b0;
    ch_enable = 4'b0000;
    burst_thr = 8'd16;
    src_req   = 4'b0000;
    src_level = 32'd0;
    dma_ack   = 4'b0000;

    // reset
    steps(3);
    chk("rst_outputs", {src_ack, dma_req, dma_single, busy, tmo_err}, 20'h0);
    reset_reset_n = 1'b1;
    steps(3);

    // basic burst: req at base, dma_req at base+2, ack at base+10
    ch_enable = 4'b0001;
    src_level = {8'd0, 8'd8, 8'd3, 8'd32};
    src_req   = 4'b0001;
    step();
    chk("t1_req_c1", dma_req[0], 1'b0);
    src_req = 4'b0000;
    step();
    chk("t1_req_c2", dma_req[0], 1'b1);
    chk("t1_sgl_c2", dma_single[0], 1'b0);
    steps(8);
    dma_ack = 4'b0001;
    step();
    chk("t1_ack_c11", src_ack[0], 1'b1);
    chk("t1_req_c11", dma_req[0], 1'b0);
    dma_ack = 4'b0000;
    step();
    chk("t1_ack_c12", src_ack[0], 1'b0);
    steps(3);

    // single request and gap spacing with src_req held
    src_level = {8'd0, 8'd8, 8'd3, 8'd3};
    src_req   = 4'b0001;
    steps(2);
    chk("t2_sgl_on", dma_single[0], 1'b1);
    chk("t2_req_off", dma_req[0], 1'b0);
    steps(3);
    dma_ack = 4'b0001;
    step();
    chk("t2_ack", src_ack[0], 1'b1);
    dma_ack = 4'b0000;
    steps(3);
    chk("t2_gap_a4", dma_single[0], 1'b0);
    step();
    chk("t2_next_a5", dma_single[0], 1'b1);
    dma_ack = 4'b0001;
    src_req = 4'b0000;
    step();
    dma_ack = 4'b0000;
    steps(4);

    // all channels concurrently, staggered acks, stray ack during issue
    for (int t = 0; t < 2; t++) begin
      burst_thr = thr_tab[t];
      ch_enable = 4'b1111;
      src_level = {8'd0, 8'd8, 8'd3, 8'd32};
      for (int k = 0; k < 14; k++) begin
        src_req = (k == 0) ? 4'b1111 : 4'b0000;
        for (int c = 0; c < NCH; c++) dma_ack[c] = (k == ack_at[c]) || (k == 1);
        step();
        if (k == 1) begin
          chk("t3_req_kind", dma_req, req_tab[t]);
          chk("t3_sgl_kind", dma_single, sgl_tab[t]);
        end
        if (k == 4) chk("t3_ack0_only", src_ack, 4'b0001);
      end
      dma_ack = 4'b0000;
      steps(3);
    end

    // enable drop coincident with ack, then stray ack in IDLE
    burst_thr = 8'd16;
    ch_enable = 4'b0010;
    src_req   = 4'b0010;
    steps(2);
    chk("t4_sgl_on", dma_single[1], 1'b1);
    ch_enable = 4'b0000;
    dma_ack   = 4'b0010;
    src_req   = 4'b0000;
    step();
    chk("t4_no_ack", src_ack[1], 1'b0);
    chk("t4_sgl_off", dma_single[1], 1'b0);
    ch_enable = 4'b0010;
    steps(2);
    chk("t4_stray_ack", src_ack[1], 1'b0);
    chk("t4_stray_busy", busy[1], 1'b0);
    dma_ack = 4'b0000;
    steps(2);

    // ack timeout on channel 3
    ch_enable = 4'b1000;
    src_req   = 4'b1000;
    steps(2);
    chk("t5_sgl_on", dma_single[3], 1'b1);
    src_req = 4'b0000;
    steps(TMO_LIMIT - 1);
    chk("t5_still_on", dma_single[3], 1'b1);
    chk("t5_no_tmo_yet", tmo_err[3], 1'b0);
    step();
    chk("t5_tmo_set", tmo_err[3], 1'b1);
    chk("t5_sgl_dropped", dma_single[3], 1'b0);
    chk("t5_no_src_ack", src_ack[3], 1'b0);
    steps(4);
    chk("t5_tmo_sticky", tmo_err[3], 1'b1);
    ch_enable = 4'b0000;
    step();
    chk("t5_tmo_clr", tmo_err[3], 1'b0);

    // async reset while waiting for ack
    ch_enable = 4'b0001;
    src_level = {8'd0, 8'd8, 8'd3, 8'd32};
    src_req   = 4'b0001;
    steps(2);
    chk("t6_req_on", dma_req[0], 1'b1);
    reset_reset_n = 1'b0;
    #1;
    chk("t6_async_req", dma_req[0], 1'b0);
    chk("t6_async_busy", busy[0], 1'b0);
    chk("t6_async_sgl", dma_single[0], 1'b0);
    ch_enable = 4'b0000;
    src_req   = 4'b0000;
    steps(2);
    reset_reset_n = 1'b1;
    steps(3);
    ch_enable = 4'b0001;
    src_req   = 4'b0001;
    steps(2);
    chk("t6_resume_req", dma_req[0], 1'b1);
    src_req = 4'b0000;
    dma_ack = 4'b0001;
    step();
    chk("t6_resume_ack", src_ack[0], 1'b1);
    dma_ack = 4'b0000;
    steps(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
